// File: rtl/p2s_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : p2s_serial_tx
//  Purpose  : Parallel-to-serial transmitter. Shifts a DATA_W-bit word out
//             MSB first on a divided serial clock, then pulses a latch strobe
//             so an external edge-triggered shift/latch chain updates its
//             outputs.
//  Optional : `define P2S_PARITY_EN appends an even-parity bit (XOR of all
//             captured data bits) after the LSB.
//  Ports    : clk    - system clock, rising edge
//             rst    - asynchronous reset, active-high
//             start  - send request, sampled only when idle
//             data   - word to send, captured on the accepting edge
//             busy   - high from the cycle after acceptance through DONE
//             done   - one-cycle completion pulse
//             sclk   - serial clock to the chain
//             sout   - serial data, changes only at the start of a low phase
//             slatch - latch strobe to the chain, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module p2s_serial_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sout,
    output logic              slatch
);

`ifdef P2S_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif

    localparam int PH_W = $clog2(CLK_DIV) + 1;
    localparam int BT_W = $clog2(N) + 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BT_W-1:0] BIT_LAST = BT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [BT_W-1:0] bit_q,   bit_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic            sclk_q,  sclk_d;
    logic            slatch_q, slatch_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic            w_ph_last;
    logic [N-1:0]    w_capture;

    assign w_ph_last = (phase_q == PH_LAST);

    // The parity bit sits below the LSB so it simply falls out last.
`ifdef P2S_PARITY_EN
    assign w_capture = {data, ^data};
`else
    assign w_capture = data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            slatch_q <= slatch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        slatch_d = slatch_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    shreg_d  = w_capture;
                    phase_d  = '0;
                    bit_d    = '0;
                    sclk_d   = 1'b0;
                    slatch_d = 1'b0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            S_SHIFT: begin
                if (w_ph_last) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of a high phase: next bit or hand over to latch.
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d  = S_LATCH;
                            slatch_d = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_LATCH: begin
                if (w_ph_last) begin
                    phase_d  = '0;
                    slatch_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // sout comes straight from the top flop of the shift register; the
    // register is left untouched after the last bit so sout holds in idle.
    assign sout   = shreg_q[N-1];
    assign sclk   = sclk_q;
    assign slatch = slatch_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_p2s_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p2s_serial_tx
//  Purpose  : Self-checking bench for p2s_serial_tx. Two instances: an 8-bit
//             word with a divide-by-2 serial clock, and a 1-bit word with a
//             divide-by-1 serial clock. Expected outputs per cycle come from
//             the timing formulas and the MSB-first bit list of each word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_p2s_serial_tx;

`ifdef P2S_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] data_a;
    logic [0:0] data_b;
    logic       busy_a, done_a, sclk_a, sout_a, slatch_a;
    logic       busy_b, done_b, sclk_b, sout_b, slatch_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    p2s_serial_tx #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a),
        .busy(busy_a), .done(done_a), .sclk(sclk_a), .sout(sout_a),
        .slatch(slatch_a)
    );

    p2s_serial_tx #(.DATA_W(1), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .sclk(sclk_b), .sout(sout_b),
        .slatch(slatch_b)
    );

    // Observed outputs packed as {sclk, sout, slatch, busy, done}.
    function automatic logic [4:0] obs(input bit sel);
        if (sel) return {sclk_b, sout_b, slatch_b, busy_b, done_b};
        return {sclk_a, sout_a, slatch_a, busy_a, done_a};
    endfunction

    // Reference model: expected {sclk, sout, slatch, busy, done} in cycle k
    // after acceptance of word (dw data bits, n serial bits, divider c).
    function automatic logic [4:0] model(input int k, input logic [7:0] word,
                                         input int dw, input int n, input int c);
        logic bits [0:8];
        logic par;
        int   d;
        par = 1'b0;
        for (int i = 0; i < dw; i++) begin
            bits[i] = word[dw-1-i];
            par     = par ^ word[i];
        end
        if (n > dw) bits[dw] = par;
        d = 2*c*n + c + 1;
        if (k <= 2*c*n)
            return {((k-1) % (2*c)) >= c, bits[(k-1)/(2*c)], 1'b0, 1'b1, 1'b0};
        if (k <= 2*c*n + c)
            return {1'b0, bits[n-1], 1'b1, 1'b1, 1'b0};
        if (k == d)
            return {1'b0, bits[n-1], 1'b0, 1'b1, 1'b1};
        return {1'b0, bits[n-1], 1'b0, 1'b0, 1'b0};
    endfunction

    // Runs one transfer from an idle negedge through cycle D+1.
    //   hold : keep start=1 throughout and switch data to alt at cycle 5
    //          (and keep it for a following acceptance at the end of D+1)
    //   noise: random start/data while busy, start=0 for cycle D+1
    task automatic transfer(input string name, input bit sel, input logic [7:0] word,
                            input bit hold, input logic [7:0] alt, input bit noise);
        int dw, n, c, d;
        logic [4:0] got, exp;
        dw = sel ? 1 : 8;
        c  = sel ? 1 : 2;
        n  = dw + PAR;
        d  = 2*c*n + c + 1;
        if (sel) begin start_b = 1'b1; data_b = word[0]; end
        else     begin start_a = 1'b1; data_a = word;    end
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            got = obs(sel);
            exp = model(k, word, dw, n, c);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s cyc %0d: got {sclk,sout,slatch,busy,done}=%b required %b",
                         name, k, got, exp);
            end
            if (hold) begin
                if (k == 5) begin
                    if (sel) data_b = alt[0]; else data_a = alt;
                end
            end else if (noise && k < d) begin
                if (sel) begin start_b = 1'($urandom_range(0, 1)); data_b = 1'($urandom); end
                else     begin start_a = 1'($urandom_range(0, 1)); data_a = 8'($urandom); end
            end else begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        tests++;
        if ({obs(0), obs(1)} !== 10'b0) begin
            fails++;
            $display("FAIL %s: got a=%b b=%b required all zero", name, obs(0), obs(1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        transfer("basic_A5", 0, 8'hA5, 0, 8'h00, 0);
        transfer("basic_5A", 0, 8'h5A, 0, 8'h00, 0);
        transfer("basic_00", 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            transfer("random", 0, 8'($urandom), 0, 8'h00, t[0]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        transfer("busy_hold_A5", 0, 8'hA5, 1, 8'h3C, 0);
        // start is still high here, so the next edge accepts 8'h3C
        transfer("busy_next_3C", 0, 8'h3C, 0, 8'h00, 0);
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1; data_a = 8'h96;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        #2 rst = 1'b1;
        #1 check_idle_zero("reset_async");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (slatch_a !== 1'b0 || busy_a !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: got slatch=%b busy=%b required 0 0", slatch_a, busy_a);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_release");
        transfer("after_reset_FF", 0, 8'hFF, 0, 8'h00, 0);
    endtask

    task automatic test_divider_boundary();
        transfer("div1_w1_one", 1, 8'h01, 0, 8'h00, 0);
        transfer("div1_w1_zero", 1, 8'h00, 0, 8'h00, 0);
        transfer("div1_w1_one_again", 1, 8'h01, 0, 8'h00, 1);
    endtask

    task automatic test_parity();
        transfer("parity_01", 0, 8'h01, 0, 8'h00, 0);
        transfer("parity_A5", 0, 8'hA5, 0, 8'h00, 0);
        transfer("parity_07", 0, 8'h07, 0, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        test_divider_boundary();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p2s_serial_tx.md
# p2s_serial_tx

- Parallel-to-serial transmitter that shifts a DATA_W-bit word out MSB first on a slow serial clock, then pulses a latch strobe.
- It drives the external serial chain of edge-triggered flip-flops (shift register and output latch) that holds the board LED and segment outputs.
- It is the sending end of that chain: the chain's flip-flops sample `sout` on each `sclk` rising edge, and `slatch` transfers the shifted word to their outputs.

## Interface
- DATA_W, 16: payload width in bits; must be at least 1.
- CLK_DIV, 4: `clk` cycles per `sclk` half-period; must be at least 1.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request to send; sampled only in IDLE.
- data  input  DATA_W  word to send; captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- sclk  output  1  serial clock to the chain.
- sout  output  1  serial data; stable for the entire high phase of `sclk`.
- slatch  output  1  latch strobe to the chain, active-high.

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- N is the number of serial bits: DATA_W, plus 1 when parity is compiled in (see Configuration).
- IDLE
  - `sclk`=0, `slatch`=0, `busy`=0, `done`=0; `sout` holds its last value.
  - start=1 on an edge: capture `data` into the shift register, clear the bit and phase counters, go to SHIFT.
- SHIFT
  - Each bit takes 2*CLK_DIV cycles: CLK_DIV cycles with `sclk`=0, then CLK_DIV cycles with `sclk`=1.
  - `sout` changes only at the start of a low phase. The chain therefore samples on the `sclk` rise, mid-bit.
  - After the high phase of bit N-1, go to LATCH with `sclk` returning to 0.
- LATCH
  - `slatch`=1 and `sclk`=0 for CLK_DIV cycles, then go to DONE.
- DONE
  - One cycle with `done`=1 and `busy`=1, then go to IDLE.
- `start` outside IDLE is ignored, including in the DONE cycle. `data` changes after capture do not affect the transfer in progress.
- Counters:
  - Phase counter width is clog2(CLK_DIV)+1.
  - Bit counter width is clog2(N)+1.
  - Neither counter wraps mid-transfer; both are cleared on acceptance.

## Timing
- Cycle k is the k-th clk cycle after the edge that accepts `start` (k ≥ 1).
- Bit i (i = 0..N-1, MSB first):
  - `sclk`=0 in cycles 2*CLK_DIV*i+1 .. 2*CLK_DIV*i+CLK_DIV.
  - `sclk`=1 in the next CLK_DIV cycles.
  - `sout` carries bit i throughout both phases.
- `slatch`=1 in cycles 2*CLK_DIV*N+1 .. 2*CLK_DIV*N+CLK_DIV.
- `done`=1 only in cycle D = 2*CLK_DIV*N+CLK_DIV+1.
- `busy`=1 in cycles 1..D. The next `start` can be accepted no earlier than the edge ending cycle D+1.
- All outputs are registered; there is no combinational path from `start` or `data` to any output.
- Reset:
  - rst=1 forces immediately: state=IDLE, `sclk`=0, `sout`=0, `slatch`=0, `busy`=0, `done`=0.
  - Shift register and counters are cleared.
  - Reset mid-transfer aborts with no `slatch` pulse, so the chain outputs keep their previous word.
  - The first `start` after rst falls behaves exactly as from power-up.

## Configuration
- P2S_PARITY_EN defined:
  - N = DATA_W+1.
  - An even-parity bit equal to XOR of all captured data bits is sent as the final bit, after the LSB.
- P2S_PARITY_EN undefined:
  - N = DATA_W; no parity logic exists.
- All timing formulas use N.

## Test plan
- Basic send. DATA_W=8, CLK_DIV=2, data=8'hA5, one-cycle start.
  - `sout` sampled on the 8 `sclk` rises is 1,0,1,0,0,1,0,1.
  - `slatch`=1 in cycles 33–34; `done` only in cycle 35; `busy` in cycles 1–35.
- Busy ignore. Same setup; start=1 held through cycles 1–35 with data changed to 8'h3C at cycle 5.
  - Transfer still sends 8'hA5.
  - Second transfer accepted at the edge ending cycle 36 sends 8'h3C.
- Reset mid-transfer. Assert rst asynchronously in cycle 10.
  - Outputs go to 0 without waiting for a clk edge; no `slatch` pulse occurs.
  - A new start with 8'hFF then sends eight 1s.
- Divider boundary. CLK_DIV=1, DATA_W=1, data=1.
  - `sclk` is 0 in cycle 1 and 1 in cycle 2, with `sout`=1.
  - `slatch` in cycle 3, `done` in cycle 4.
- Parity, with P2S_PARITY_EN defined, DATA_W=8, CLK_DIV=2.
  - data=8'h01 sends 0,0,0,0,0,0,0,1,1: 9 rises, `done` in cycle 39.
  - data=8'hA5 sends a final parity bit of 0.
